// File: rtl/next_pc_predictor.sv
// next_pc_predictor: fetch PC register, PC+4 lookup, 2-bit direction table and registered BTB write port.
module next_pc_predictor #(
  parameter int PHT_BITS = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_in,
  input  logic [63:0] PPC_in,
  input  logic        mispredict_in,
  input  logic [63:0] recovery_PC_in,
  input  logic        update_valid_in,
  input  logic [63:0] update_NPC_in,
  input  logic        update_taken_in,
  input  logic [63:0] update_target_in,
  output logic [63:0] fetch_PC_out,
  output logic [63:0] fetch_NPC_out,
  output logic        pred_taken_out,
  output logic [63:0] pred_PC_out,
  output logic        btb_write_out,
  output logic [63:0] btb_write_NPC_out,
  output logic [63:0] btb_write_dest_out
);
  localparam int N = 1 << PHT_BITS;
  logic [63:0] pc_q, pc_d, wr_npc_q, wr_npc_d, wr_dest_q, wr_dest_d;
  logic        wr_q, wr_d;
  logic [1:0]  pht_q [N];
  logic [1:0]  pht_d [N];
  logic [1:0]  cnt;
  logic [PHT_BITS-1:0] uidx;
  assign fetch_PC_out       = pc_q;
  assign fetch_NPC_out      = pc_q + 64'd4;
  // an all-zero BTB target means no entry, so never redirect to it
  assign pred_taken_out     = pht_q[fetch_NPC_out[PHT_BITS-1:0]][1] && (PPC_in != 64'd0);
  assign pred_PC_out        = pred_taken_out ? PPC_in : fetch_NPC_out;
  assign btb_write_out      = wr_q;
  assign btb_write_NPC_out  = wr_npc_q;
  assign btb_write_dest_out = wr_dest_q;
  assign uidx = update_NPC_in[PHT_BITS-1:0];
  assign cnt  = pht_q[uidx];
  always_comb begin
    pc_d      = mispredict_in ? recovery_PC_in : stall_in ? pc_q : pred_PC_out;
    wr_d      = update_valid_in && update_taken_in;
    wr_npc_d  = wr_d ? update_target_in : wr_npc_q;
    wr_dest_d = wr_d ? update_NPC_in : wr_dest_q;
    pht_d     = pht_q;
    if (update_valid_in)
      pht_d[uidx] = update_taken_in ? ((cnt == 2'b11) ? cnt : cnt + 2'd1)
                                    : ((cnt == 2'b00) ? cnt : cnt - 2'd1);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      wr_q      <= 1'b0;
      wr_npc_q  <= 64'd0;
      wr_dest_q <= 64'd0;
      for (int i = 0; i < N; i++) pht_q[i] <= 2'b01;
    end else begin
      pc_q      <= pc_d;
      wr_q      <= wr_d;
      wr_npc_q  <= wr_npc_d;
      wr_dest_q <= wr_dest_d;
      pht_q     <= pht_d;
    end
  end
endmodule

// File: tb/tb_next_pc_predictor.sv
// tb_next_pc_predictor: directed fetch, training, BTB-write, stall/redirect and reset checks.
module tb_next_pc_predictor;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0;
  logic [63:0] PPC_in = 64'd0;
  logic        mispredict_in = 1'b0;
  logic [63:0] recovery_PC_in = 64'd0;
  logic        update_valid_in = 1'b0;
  logic [63:0] update_NPC_in = 64'd0;
  logic        update_taken_in = 1'b0;
  logic [63:0] update_target_in = 64'd0;
  logic [63:0] fetch_PC_out, fetch_NPC_out, pred_PC_out, btb_write_NPC_out, btb_write_dest_out;
  logic        pred_taken_out, btb_write_out;
  int n_cmp = 0;
  int n_bad = 0;

  next_pc_predictor #(.PHT_BITS(4), .RESET_PC(64'd0)) dut (
    .clock(clock), .reset(reset), .stall_in(stall_in), .PPC_in(PPC_in),
    .mispredict_in(mispredict_in), .recovery_PC_in(recovery_PC_in),
    .update_valid_in(update_valid_in), .update_NPC_in(update_NPC_in),
    .update_taken_in(update_taken_in), .update_target_in(update_target_in),
    .fetch_PC_out(fetch_PC_out), .fetch_NPC_out(fetch_NPC_out),
    .pred_taken_out(pred_taken_out), .pred_PC_out(pred_PC_out),
    .btb_write_out(btb_write_out), .btb_write_NPC_out(btb_write_NPC_out),
    .btb_write_dest_out(btb_write_dest_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic upd(input logic taken, input logic [63:0] npc, input logic [63:0] tgt, input int cycles);
    update_valid_in = 1'b1;
    update_taken_in = taken;
    update_NPC_in = npc;
    update_target_in = tgt;
    repeat (cycles) tick();
    update_valid_in = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_pc", fetch_PC_out, 64'd0);
    chk("rst_npc", fetch_NPC_out, 64'd4);
    chk("rst_pred", {63'd0, pred_taken_out}, 64'd0);
    chk("rst_wr", {63'd0, btb_write_out}, 64'd0);
    chk("rst_wr_npc", btb_write_NPC_out, 64'd0);
    chk("rst_wr_dest", btb_write_dest_out, 64'd0);
    #11 reset = 1'b1;
    #1 chk("rel_pc", fetch_PC_out, 64'd0);
    tick(); chk("seq_pc4", fetch_PC_out, 64'd4);
    tick(); chk("seq_pc8", fetch_PC_out, 64'd8);
    tick(); chk("seq_pc12", fetch_PC_out, 64'd12);
    chk("seq_pred", {63'd0, pred_taken_out}, 64'd0);
    chk("seq_wr", {63'd0, btb_write_out}, 64'd0);
    // wrap of PC+4
    mispredict_in = 1'b1; recovery_PC_in = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(); chk("wrap_pc", fetch_PC_out, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_npc", fetch_NPC_out, 64'd0);
    recovery_PC_in = 64'd0;
    tick(); chk("redir_pc0", fetch_PC_out, 64'd0);
    mispredict_in = 1'b0; stall_in = 1'b1; PPC_in = 64'h100;
    #1 chk("weak_nt_pred", {63'd0, pred_taken_out}, 64'd0);
    chk("weak_nt_ppc", pred_PC_out, 64'd4);
    // first taken update: same-cycle prediction still sees the old counter
    update_valid_in = 1'b1; update_taken_in = 1'b1; update_NPC_in = 64'h4; update_target_in = 64'h100;
    #1 chk("same_cyc_old", {63'd0, pred_taken_out}, 64'd0);
    tick();
    chk("tr1_pred", {63'd0, pred_taken_out}, 64'd1);
    chk("tr1_wr", {63'd0, btb_write_out}, 64'd1);
    chk("tr1_wr_npc", btb_write_NPC_out, 64'h100);
    chk("tr1_wr_dest", btb_write_dest_out, 64'h4);
    tick();
    update_valid_in = 1'b0; stall_in = 1'b0;
    #1 chk("tr2_pred", {63'd0, pred_taken_out}, 64'd1);
    chk("tr2_ppc", pred_PC_out, 64'h100);
    chk("tr2_wr", {63'd0, btb_write_out}, 64'd1);
    tick(); chk("taken_pc", fetch_PC_out, 64'h100);
    chk("wr_drop", {63'd0, btb_write_out}, 64'd0);
    stall_in = 1'b1; PPC_in = 64'd0;
    #1 chk("zero_ppc_nt", {63'd0, pred_taken_out}, 64'd0);
    upd(1'b1, 64'h8, 64'h200, 1);
    chk("btbw_en", {63'd0, btb_write_out}, 64'd1);
    chk("btbw_npc", btb_write_NPC_out, 64'h200);
    chk("btbw_dest", btb_write_dest_out, 64'h8);
    tick();
    chk("btbw_off", {63'd0, btb_write_out}, 64'd0);
    chk("btbw_hold_npc", btb_write_NPC_out, 64'h200);
    chk("btbw_hold_dest", btb_write_dest_out, 64'h8);
    chk("stall_pc", fetch_PC_out, 64'h100);
    // saturation on index 0xC
    mispredict_in = 1'b1; recovery_PC_in = 64'h8;
    tick(); mispredict_in = 1'b0; PPC_in = 64'h300;
    chk("sat_pc", fetch_PC_out, 64'h8);
    #1 chk("sat_init", {63'd0, pred_taken_out}, 64'd0);
    upd(1'b1, 64'hC, 64'h300, 5);
    upd(1'b0, 64'hC, 64'h300, 1);
    chk("sat_hi_10", {63'd0, pred_taken_out}, 64'd1);
    upd(1'b0, 64'hC, 64'h300, 1);
    chk("sat_hi_01", {63'd0, pred_taken_out}, 64'd0);
    upd(1'b0, 64'hC, 64'h300, 5);
    chk("sat_lo", {63'd0, pred_taken_out}, 64'd0);
    upd(1'b1, 64'hC, 64'h300, 1);
    chk("sat_lo_01", {63'd0, pred_taken_out}, 64'd0);
    upd(1'b1, 64'hC, 64'h300, 1);
    chk("sat_lo_10", {63'd0, pred_taken_out}, 64'd1);
    // recovery beats stall, then stall holds
    mispredict_in = 1'b1; recovery_PC_in = 64'h340; PPC_in = 64'd0;
    tick(); mispredict_in = 1'b0;
    chk("recov_pc", fetch_PC_out, 64'h340);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hold_pc", fetch_PC_out, 64'h340);
    end
    // asynchronous reset mid-run
    mispredict_in = 1'b1; recovery_PC_in = 64'h100; PPC_in = 64'h500;
    tick(); mispredict_in = 1'b0;
    chk("pre_rst_pred", {63'd0, pred_taken_out}, 64'd1);
    #2 reset = 1'b0;
    #1 chk("arst_pc", fetch_PC_out, 64'd0);
    chk("arst_npc", fetch_NPC_out, 64'd4);
    chk("arst_wr", {63'd0, btb_write_out}, 64'd0);
    chk("arst_wr_npc", btb_write_NPC_out, 64'd0);
    chk("arst_wr_dest", btb_write_dest_out, 64'd0);
    #2 reset = 1'b1;
    mispredict_in = 1'b1;
    tick(); mispredict_in = 1'b0;
    chk("post_rst_pc", fetch_PC_out, 64'h100);
    chk("post_rst_pred", {63'd0, pred_taken_out}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/next_pc_predictor.md
# next_pc_predictor

Fetch-stage next-PC generator that sits directly upstream of the branch target buffer. It holds the fetch PC and presents PC+4 to the BTB lookup port. It combines the returned predicted target with a table of 2-bit saturating direction counters to choose the next fetch PC. It also trains those counters from resolved-branch updates and drives the registered BTB write port.

## Interface
- PHT_BITS, 4, index width of the direction table (2^PHT_BITS counters); must equal the BTB index width
- RESET_PC, 64'd0, fetch PC loaded on reset
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state initialised while low
- stall_in  in  1  hold fetch PC (front-end back-pressure)
- PPC_in  in  64  predicted target returned by BTB for fetch_NPC_out (same cycle, combinational)
- mispredict_in  in  1  redirect fetch to recovery_PC_in
- recovery_PC_in  in  64  correct PC after mispredict
- update_valid_in  in  1  a branch resolved this cycle
- update_NPC_in  in  64  NPC of the resolved branch (index source)
- update_taken_in  in  1  resolved direction
- update_target_in  in  64  resolved taken target
- fetch_PC_out  out  64  current fetch PC (register)
- fetch_NPC_out  out  64  fetch_PC_out + 4; drives BTB lookup
- pred_taken_out  out  1  prediction for current fetch
- pred_PC_out  out  64  chosen next PC (PPC_in or fetch_NPC_out)
- btb_write_out  out  1  registered BTB write enable
- btb_write_NPC_out  out  64  registered BTB write data (target)
- btb_write_dest_out  out  64  registered BTB write index source (branch NPC)

## Operation
- Direction table: 2^PHT_BITS 2-bit counters, states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; all reset to 01.
- Prediction index = fetch_NPC_out[PHT_BITS-1:0].
- pred_taken_out = counter[idx][1] && (PPC_in != 64'd0); an all-zero BTB target means no entry exists and is always not-taken.
- pred_PC_out = pred_taken_out ? PPC_in : fetch_NPC_out.
- fetch_NPC_out = fetch_PC_out + 64'd4, modulo 2^64 (wraps, no flag).
- PC register priority at each edge: mispredict_in loads recovery_PC_in; else stall_in holds; else pred_PC_out is loaded.
- Training: when update_valid_in, counter[update_NPC_in[PHT_BITS-1:0]] increments on taken and decrements on not-taken, saturating at 11 and 00. update_valid_in is independent of stall_in and mispredict_in.
- BTB write: next cycle btb_write_out = update_valid_in && update_taken_in; on that condition btb_write_NPC_out/btb_write_dest_out capture update_target_in/update_NPC_in, else they hold their previous values.

## Timing
- Reset (reset low, any time, including mid-operation): fetch_PC_out=RESET_PC, fetch_NPC_out=RESET_PC+4, all counters 01, btb_write_out=0, btb_write_NPC_out=0, btb_write_dest_out=0. pred_taken_out is 0 because counters reset to 01.
- Prediction is combinational in the same cycle as the BTB lookup; redirect takes effect at the next rising edge (1-cycle fetch loop).
- Counter updates become visible to prediction one cycle after update_valid_in. For a same-cycle update and prediction on the same index, prediction uses the old counter value.
- The BTB write is issued one cycle after the update, so a taken branch's target can first be predicted two cycles after resolution.
- mispredict_in with stall_in: recovery wins. mispredict_in with update_valid_in: both take effect.
- Back-to-back updates to the same index accumulate, one step per cycle.

## Test plan
- Reset then release, PPC_in=0, no stall: fetch_PC_out = 0,4,8,12 on successive cycles; pred_taken_out=0; btb_write_out=0.
- Counter at 01, PPC_in=0x100 at fetch_NPC_out=0x4: pred_taken_out=0 and next PC=0x4. Apply two taken updates with update_NPC_in=0x4 and update_target_in=0x100; then fetch at NPC 0x4 with PPC_in=0x100 gives pred_taken_out=1 and next fetch_PC_out=0x100.
- One taken update with update_NPC_in=0x8 and update_target_in=0x200: btb_write_out=1 for exactly one cycle, with btb_write_NPC_out=0x200 and btb_write_dest_out=0x8.
- Counter saturation: five taken updates on one index then one not-taken leaves it at 10 (still predicts taken). Five not-taken updates leave it at 00.
- stall_in=1 and mispredict_in=1 with recovery_PC_in=0x340: fetch_PC_out=0x340 next cycle. With stall_in=1 alone, the PC holds for N cycles.
- reset asserted mid-run after training (PC=0x100): outputs go to reset values immediately without a clock edge. Counters return to 01, so the trained index predicts not-taken after release.
